// File: rtl/eth_pcs_pkg.sv
// Shared constants for the 64b/66b PCS transmit path.
//   N_CHANNELS : XGMII lanes carried per transfer
//   W_BYTE     : bits per XGMII lane
//   W_DATA     : payload bits per transfer (half a 64-bit block)
//   W_SYNC     : sync header width
//   SYNC_DATA / SYNC_CTRL : the two legal sync header values
package eth_pcs_pkg;
    localparam int N_CHANNELS = 4;
    localparam int W_BYTE     = 8;
    localparam int W_DATA     = 32;
    localparam int W_SYNC     = 2;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
endpackage

// File: rtl/eth_pcs_64_66_encoder.sv
// 64b/66b block encoder fed by a 32-bit XGMII half-rate interface.
// Two enabled transfers (phase 0 = lanes 0-3, phase 1 = lanes 4-7) form one
// 64-bit block, which is classified, run through the transmit state machine
// and emitted as a sync header plus two 32-bit payload halves.
//
// Ports:
//   i_clk         : clock
//   i_reset_n     : asynchronous active-low reset
//   i_clk_en      : gearbox cycle enable, nothing advances while low
//   i_xgmii_ctrl  : per-lane control flags, lane 0 = bit 0
//   i_xgmii_data  : per-lane bytes, lane k at [8k+7:8k]
//   o_hdr_valid   : high on the transfer carrying payload[31:0] of a block
//   o_hdr         : sync header of the current block
//   o_data        : unscrambled payload half
module eth_pcs_64_66_encoder
    import eth_pcs_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_clk_en,
    input  logic [N_CHANNELS-1:0]        i_xgmii_ctrl,
    input  logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data,
    output logic                         o_hdr_valid,
    output logic [W_SYNC-1:0]            o_hdr,
    output logic [W_DATA-1:0]            o_data
);
    localparam int N_LANES = 2 * N_CHANNELS;
    localparam int W_BLOCK = 2 * W_DATA;

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERROR = 8'hFE;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [7:0] TYPE_CTRL = 8'h1E;
    localparam logic [7:0] TYPE_S0   = 8'h78;
    localparam logic [7:0] TYPE_S4   = 8'h33;

    localparam logic [W_BLOCK-1:0] EBLOCK = {{N_LANES{CODE_ERROR}}, TYPE_CTRL};

    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
    typedef enum logic [2:0] {CLS_C, CLS_S, CLS_D, CLS_T, CLS_E} blk_class_t;

    logic                         phase;
    logic [N_CHANNELS-1:0]        lane_ctrl_p0;
    logic [N_CHANNELS*W_BYTE-1:0] lane_data_p0;
    logic [N_LANES-1:0]           blk_ctrl;
    logic [W_BLOCK-1:0]           blk_data;
    logic [N_LANES-1:0]           lane_idle;
    logic [N_LANES-1:0]           lane_err;
    blk_class_t                   blk_class;
    logic [W_BLOCK-1:0]           enc_payload;
    tx_state_t                    state;
    tx_state_t                    state_next;
    logic [W_BLOCK-1:0]           blk_p1;
    logic [W_SYNC-1:0]            hdr_p1;
    logic                         vld_p1;

    function automatic logic [7:0] term_type(input logic [2:0] n);
        case (n)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    // Data bytes ahead of a terminate in lane n; the pad bits and the
    // trailing idle codes are all zero, so everything above stays 0.
    function automatic logic [55:0] term_bytes(input logic [W_BLOCK-1:0] data, input int n);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < N_LANES - 1; i++) begin
            if (i < n) r[i*W_BYTE +: W_BYTE] = data[i*W_BYTE +: W_BYTE];
        end
        return r;
    endfunction

    assign blk_ctrl = {i_xgmii_ctrl, lane_ctrl_p0};
    assign blk_data = {i_xgmii_data, lane_data_p0};

    always_comb begin
        lane_idle = '0;
        lane_err  = '0;
        for (int k = 0; k < N_LANES; k++) begin
            lane_idle[k] = blk_ctrl[k] && (blk_data[k*W_BYTE +: W_BYTE] == XG_IDLE);
            lane_err[k]  = blk_ctrl[k] && (blk_data[k*W_BYTE +: W_BYTE] == XG_ERROR);
        end
    end

    // Block classification and encoding. Anything that does not match one
    // of the recognised layouts exactly falls through as class E.
    always_comb begin
        blk_class   = CLS_E;
        enc_payload = '0;
        if (blk_ctrl == '0) begin
            blk_class   = CLS_D;
            enc_payload = blk_data;
        end else if (&(lane_idle | lane_err)) begin
            blk_class        = CLS_C;
            enc_payload[7:0] = TYPE_CTRL;
            for (int k = 0; k < N_LANES; k++) begin
                enc_payload[8 + 7*k +: 7] = lane_err[k] ? CODE_ERROR : CODE_IDLE;
            end
        end else if (blk_ctrl == 8'h01 && blk_data[7:0] == XG_START) begin
            blk_class   = CLS_S;
            enc_payload = {blk_data[63:8], TYPE_S0};
        end else if (blk_ctrl == 8'h1F && (&lane_idle[3:0]) && blk_data[39:32] == XG_START) begin
            blk_class   = CLS_S;
            enc_payload = {blk_data[63:40], 32'h0, TYPE_S4};
        end else begin
            for (int n = 0; n < N_LANES; n++) begin
                if (blk_ctrl == 8'(8'hFF << n)
                    && blk_data[n*W_BYTE +: W_BYTE] == XG_TERM
                    && ((lane_idle & 8'(8'hFE << n)) == 8'(8'hFE << n))) begin
                    blk_class   = CLS_T;
                    enc_payload = {term_bytes(blk_data, n), term_type(3'(n))};
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_INIT, TX_C, TX_T: begin
                if (blk_class == CLS_C)      state_next = TX_C;
                else if (blk_class == CLS_S) state_next = TX_D;
                else                         state_next = TX_E;
            end
            TX_D: begin
                if (blk_class == CLS_D)      state_next = TX_D;
                else if (blk_class == CLS_T) state_next = TX_T;
                else                         state_next = TX_E;
            end
            TX_E: begin
                if (blk_class == CLS_C)      state_next = TX_C;
                else if (blk_class == CLS_D) state_next = TX_D;
                else if (blk_class == CLS_T) state_next = TX_T;
                else                         state_next = TX_E;
            end
            default: state_next = TX_E;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= TX_INIT;
        end else if (i_clk_en && phase) begin
            state <= state_next;
        end
    end

    // Stage p0: hold lanes 0-3 until the second half of the block arrives.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && !phase) begin
            lane_ctrl_p0 <= i_xgmii_ctrl;
            lane_data_p0 <= i_xgmii_data;
        end
    end

    // Stage p1: encoded block register; then the output register, which
    // serialises the block as low half (with header valid) then high half.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase       <= 1'b0;
            blk_p1      <= '0;
            hdr_p1      <= SYNC_CTRL;
            vld_p1      <= 1'b0;
            o_hdr_valid <= 1'b0;
            o_hdr       <= SYNC_CTRL;
            o_data      <= '0;
        end else if (i_clk_en) begin
            phase <= ~phase;
            if (!phase) begin
                o_hdr_valid <= vld_p1;
                o_hdr       <= hdr_p1;
                o_data      <= blk_p1[W_DATA-1:0];
            end else begin
                o_hdr_valid <= 1'b0;
                o_data      <= blk_p1[W_BLOCK-1:W_DATA];
                vld_p1      <= 1'b1;
                if (state_next == TX_E) begin
                    blk_p1 <= EBLOCK;
                    hdr_p1 <= SYNC_CTRL;
                end else begin
                    blk_p1 <= enc_payload;
                    hdr_p1 <= (blk_class == CLS_D) ? SYNC_DATA : SYNC_CTRL;
                end
            end
        end
    end

endmodule
